// File: rtl/spm_pkg.sv
// Shared constants and helpers for the banked scratchpad memory.
package spm_pkg;

    localparam logic READ     = 1'b1;
    localparam logic WRITE    = 1'b0;
    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    // Number of address bits needed to select one of 'value' banks (0 for a single bank).
    function automatic int clog2(input int value);
        int width;
        width = 0;
        while ((1 << width) < value) begin
            width++;
        end
        return width;
    endfunction

endpackage

// File: rtl/spm_bank.sv
// One single-port bank of the scratchpad: byte-enable writes, registered read data.
module spm_bank #(
    parameter int ROW_W  = 11,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [DATA_W/8-1:0]   be,
    input  logic [ROW_W-1:0]      row,
    input  logic [DATA_W-1:0]     wr_data,
    output logic [DATA_W-1:0]     rd_data
);

    localparam int DEPTH = 1 << ROW_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // Array and read register carry no reset so the bank maps onto plain block RAM.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < DATA_W / 8; i++) begin
                    if (be[i]) begin
                        mem[row][i*8 +: 8] <= wr_data[i*8 +: 8];
                    end
                end
            end else begin
                rd_data <= mem[row];
            end
        end
    end

endmodule

// File: rtl/spm_banked.sv
// Banked scratchpad shared by IF and MEM: arbiter, per-bank port mux and read-return steering.
module spm_banked
    import spm_pkg::*;
#(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 32,
    parameter int BANKS  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [ADDR_W-1:0]     if_spm_addr,
    input  logic                  if_spm_as_,
    input  logic                  if_spm_rw,
    input  logic [DATA_W-1:0]     if_spm_wr_data,
    input  logic [DATA_W/8-1:0]   if_spm_be,
    output logic                  if_spm_rdy_,
    output logic [DATA_W-1:0]     if_spm_rd_data,
    input  logic [ADDR_W-1:0]     mem_spm_addr,
    input  logic                  mem_spm_as_,
    input  logic                  mem_spm_rw,
    input  logic [DATA_W-1:0]     mem_spm_wr_data,
    input  logic [DATA_W/8-1:0]   mem_spm_be,
    output logic                  mem_spm_rdy_,
    output logic [DATA_W-1:0]     mem_spm_rd_data
);

    localparam int BANK_W    = clog2(BANKS);
    localparam int SEL_W     = (BANK_W > 0) ? BANK_W : 1;
    localparam int ROW_W     = ADDR_W - BANK_W;
    localparam int ROW_SEL_W = (ROW_W > 0) ? ROW_W : 1;
    localparam int BE_W      = DATA_W / 8;

    logic [SEL_W-1:0]     if_bank, mem_bank;
    logic [ROW_SEL_W-1:0] if_row, mem_row;

    // Low address bits pick the bank (word interleaving), the rest pick the row.
    generate
        if (BANK_W == 0) begin : g_one_bank
            assign if_bank  = '0;
            assign mem_bank = '0;
        end else begin : g_multi_bank
            assign if_bank  = if_spm_addr[SEL_W-1:0];
            assign mem_bank = mem_spm_addr[SEL_W-1:0];
        end
        if (ROW_W == 0) begin : g_no_row
            assign if_row  = '0;
            assign mem_row = '0;
        end else begin : g_row
            assign if_row  = if_spm_addr[ADDR_W-1 -: ROW_SEL_W];
            assign mem_row = mem_spm_addr[ADDR_W-1 -: ROW_SEL_W];
        end
    endgenerate

    logic if_req, mem_req, conflict, if_gnt, mem_gnt, if_prio;

    assign if_req  = (if_spm_as_ == ENABLE_);
    assign mem_req = (mem_spm_as_ == ENABLE_);

    // Grant both ports unless they hit the same bank; then the priority bit picks one.
    always_comb begin
        conflict = if_req && mem_req && (if_bank == mem_bank);
        if_gnt   = if_req && (!conflict || if_prio);
        mem_gnt  = mem_req && (!conflict || !if_prio);
    end

    assign if_spm_rdy_  = if_gnt  ? ENABLE_ : DISABLE_;
    assign mem_spm_rdy_ = mem_gnt ? ENABLE_ : DISABLE_;

    // Hand priority to the loser of each conflict so no port waits more than one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_prio <= 1'b0;
        end else if (conflict) begin
            if_prio <= mem_gnt;
        end
    end

    logic [BANKS-1:0]     bank_en, bank_we;
    logic [BE_W-1:0]      bank_be    [BANKS];
    logic [ROW_SEL_W-1:0] bank_row   [BANKS];
    logic [DATA_W-1:0]    bank_wdata [BANKS];
    logic [DATA_W-1:0]    bank_rdata [BANKS];

    // Route the granted port to its bank; writes are dropped while reset is high.
    always_comb begin
        for (int b = 0; b < BANKS; b++) begin
            bank_en[b]    = 1'b0;
            bank_we[b]    = 1'b0;
            bank_be[b]    = '0;
            bank_row[b]   = '0;
            bank_wdata[b] = '0;
            if (if_gnt && (if_bank == SEL_W'(b))) begin
                bank_en[b]    = 1'b1;
                bank_we[b]    = (if_spm_rw == WRITE) && !reset;
                bank_be[b]    = if_spm_be;
                bank_row[b]   = if_row;
                bank_wdata[b] = if_spm_wr_data;
            end else if (mem_gnt && (mem_bank == SEL_W'(b))) begin
                bank_en[b]    = 1'b1;
                bank_we[b]    = (mem_spm_rw == WRITE) && !reset;
                bank_be[b]    = mem_spm_be;
                bank_row[b]   = mem_row;
                bank_wdata[b] = mem_spm_wr_data;
            end
        end
    end

    generate
        for (genvar g = 0; g < BANKS; g++) begin : g_bank
            spm_bank #(
                .ROW_W  (ROW_SEL_W),
                .DATA_W (DATA_W)
            ) u_bank (
                .clk     (clk),
                .en      (bank_en[g]),
                .we      (bank_we[g]),
                .be      (bank_be[g]),
                .row     (bank_row[g]),
                .wr_data (bank_wdata[g]),
                .rd_data (bank_rdata[g])
            );
        end
    endgenerate

    logic              if_vld_q, mem_vld_q;
    logic [SEL_W-1:0]  if_src_q, mem_src_q;
    logic [DATA_W-1:0] if_hold_q, mem_hold_q;
    logic [DATA_W-1:0] if_word, mem_word;

    // Pick the bank output each port read from in the previous cycle.
    always_comb begin
        if_word  = '0;
        mem_word = '0;
        for (int b = 0; b < BANKS; b++) begin
            if (if_src_q == SEL_W'(b)) begin
                if_word = bank_rdata[b];
            end
            if (mem_src_q == SEL_W'(b)) begin
                mem_word = bank_rdata[b];
            end
        end
    end

    // Remember which bank answers each read, and keep a copy since the bank may be reused.
    always_ff @(posedge clk) begin
        if (reset) begin
            if_vld_q   <= 1'b0;
            mem_vld_q  <= 1'b0;
            if_src_q   <= '0;
            mem_src_q  <= '0;
            if_hold_q  <= '0;
            mem_hold_q <= '0;
        end else begin
            if (if_vld_q) begin
                if_hold_q <= if_word;
            end
            if (mem_vld_q) begin
                mem_hold_q <= mem_word;
            end
            if_vld_q  <= if_gnt && (if_spm_rw == READ);
            mem_vld_q <= mem_gnt && (mem_spm_rw == READ);
            if (if_gnt && (if_spm_rw == READ)) begin
                if_src_q <= if_bank;
            end
            if (mem_gnt && (mem_spm_rw == READ)) begin
                mem_src_q <= mem_bank;
            end
        end
    end

    assign if_spm_rd_data  = reset ? '0 : (if_vld_q  ? if_word  : if_hold_q);
    assign mem_spm_rd_data = reset ? '0 : (mem_vld_q ? mem_word : mem_hold_q);

endmodule

// File: tb/tb_spm_banked.sv
// Self-checking bench for spm_banked: directed table, randomized traffic, single-bank build.
module tb_spm_banked;

    localparam int OI  = 0;
    localparam int ORD = 1;
    localparam int OWR = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [11:0] if_addr, mem_addr;
    logic        if_as_, if_rw, mem_as_, mem_rw;
    logic [31:0] if_wd, mem_wd, if_rd, mem_rd;
    logic [3:0]  if_be, mem_be;
    logic        if_rdy_, mem_rdy_;

    spm_banked dut (
        .clk(clk), .reset(reset),
        .if_spm_addr(if_addr), .if_spm_as_(if_as_), .if_spm_rw(if_rw),
        .if_spm_wr_data(if_wd), .if_spm_be(if_be), .if_spm_rdy_(if_rdy_), .if_spm_rd_data(if_rd),
        .mem_spm_addr(mem_addr), .mem_spm_as_(mem_as_), .mem_spm_rw(mem_rw),
        .mem_spm_wr_data(mem_wd), .mem_spm_be(mem_be), .mem_spm_rdy_(mem_rdy_), .mem_spm_rd_data(mem_rd)
    );

    logic        b1_reset;
    logic [7:0]  b1_if_addr, b1_mem_addr;
    logic        b1_if_as_, b1_if_rw, b1_mem_as_, b1_mem_rw;
    logic [31:0] b1_if_wd, b1_mem_wd, b1_if_rd, b1_mem_rd;
    logic [3:0]  b1_if_be, b1_mem_be;
    logic        b1_if_rdy_, b1_mem_rdy_;

    spm_banked #(.ADDR_W(8), .DATA_W(32), .BANKS(1)) dut1 (
        .clk(clk), .reset(b1_reset),
        .if_spm_addr(b1_if_addr), .if_spm_as_(b1_if_as_), .if_spm_rw(b1_if_rw),
        .if_spm_wr_data(b1_if_wd), .if_spm_be(b1_if_be), .if_spm_rdy_(b1_if_rdy_), .if_spm_rd_data(b1_if_rd),
        .mem_spm_addr(b1_mem_addr), .mem_spm_as_(b1_mem_as_), .mem_spm_rw(b1_mem_rw),
        .mem_spm_wr_data(b1_mem_wd), .mem_spm_be(b1_mem_be), .mem_spm_rdy_(b1_mem_rdy_), .mem_spm_rd_data(b1_mem_rd)
    );

    typedef struct {
        logic        rst;
        logic        if_req;
        logic        if_rw;
        logic [11:0] if_addr;
        logic [31:0] if_wd;
        logic [3:0]  if_be;
        logic        mem_req;
        logic        mem_rw;
        logic [11:0] mem_addr;
        logic [31:0] mem_wd;
        logic [3:0]  mem_be;
        logic        chk_rdy;
        logic        exp_if_rdy_;
        logic        exp_mem_rdy_;
        logic        chk_if_rd;
        logic [31:0] exp_if_rd;
        logic        chk_mem_rd;
        logic [31:0] exp_mem_rd;
    } vec_t;

    int errors = 0;
    int checks = 0;

    // Reference model: word array, priority owner and what each port should be showing.
    logic [31:0] m_mem   [4096];
    bit          m_known [4096];
    bit          m_prio;
    logic [31:0] m_if_rd, m_mem_rd;
    bit          m_if_ok, m_mem_ok;
    bit          m_if_stall, m_mem_stall;

    logic [31:0] b1_ref [256];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic rst, input int iop, input logic [11:0] ia, input logic [31:0] id,
                                input logic [3:0] ib, input int mop, input logic [11:0] ma,
                                input logic [31:0] md, input logic [3:0] mb);
        vec_t v;
        v = '{default: '0};
        v.rst = rst;
        v.if_req = (iop != OI);  v.if_rw = (iop == ORD);  v.if_addr = ia;  v.if_wd = id;  v.if_be = ib;
        v.mem_req = (mop != OI); v.mem_rw = (mop == ORD); v.mem_addr = ma; v.mem_wd = md; v.mem_be = mb;
        return v;
    endfunction

    function automatic vec_t rdy(input vec_t v, input logic ir, input logic mr);
        vec_t r = v;
        r.chk_rdy = 1'b1; r.exp_if_rdy_ = ir; r.exp_mem_rdy_ = mr;
        return r;
    endfunction

    function automatic vec_t eif(input vec_t v, input logic [31:0] d);
        vec_t r = v;
        r.chk_if_rd = 1'b1; r.exp_if_rd = d;
        return r;
    endfunction

    function automatic vec_t emem(input vec_t v, input logic [31:0] d);
        vec_t r = v;
        r.chk_mem_rd = 1'b1; r.exp_mem_rd = d;
        return r;
    endfunction

    task automatic modelWrite(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
        for (int i = 0; i < 4; i++) begin
            if (be[i]) m_mem[a][i*8 +: 8] = d[i*8 +: 8];
        end
        if (be == 4'hF) m_known[a] = 1'b1;
    endtask

    // Drive one cycle, check against the table entry and the model, then advance the model.
    task automatic applyStimulus(input vec_t v);
        bit conflict, gi, gm;
        reset    = v.rst;
        if_as_   = ~v.if_req;  if_rw  = v.if_rw;  if_addr  = v.if_addr;  if_wd  = v.if_wd;  if_be  = v.if_be;
        mem_as_  = ~v.mem_req; mem_rw = v.mem_rw; mem_addr = v.mem_addr; mem_wd = v.mem_wd; mem_be = v.mem_be;
        @(negedge clk);
        conflict = v.if_req && v.mem_req && ((int'(v.if_addr) % 2) == (int'(v.mem_addr) % 2));
        gi = v.if_req && (!conflict || m_prio);
        gm = v.mem_req && (!conflict || !m_prio);
        checkOutput("if_rdy_model", 32'(if_rdy_), 32'(!gi));
        checkOutput("mem_rdy_model", 32'(mem_rdy_), 32'(!gm));
        if (!v.rst && m_if_ok)  checkOutput("if_rd_model", if_rd, m_if_rd);
        if (!v.rst && m_mem_ok) checkOutput("mem_rd_model", mem_rd, m_mem_rd);
        if (v.chk_rdy) begin
            checkOutput("if_rdy_table", 32'(if_rdy_), 32'(v.exp_if_rdy_));
            checkOutput("mem_rdy_table", 32'(mem_rdy_), 32'(v.exp_mem_rdy_));
        end
        if (v.chk_if_rd)  checkOutput("if_rd_table", if_rd, v.exp_if_rd);
        if (v.chk_mem_rd) checkOutput("mem_rd_table", mem_rd, v.exp_mem_rd);
        if (v.rst) begin
            m_prio = 1'b0; m_if_rd = '0; m_mem_rd = '0; m_if_ok = 1'b1; m_mem_ok = 1'b1;
            m_if_stall = 1'b0; m_mem_stall = 1'b0;
        end else begin
            if (gi && v.if_rw)  begin m_if_rd  = m_mem[v.if_addr];  m_if_ok  = m_known[v.if_addr];  end
            if (gm && v.mem_rw) begin m_mem_rd = m_mem[v.mem_addr]; m_mem_ok = m_known[v.mem_addr]; end
            if (gi && !v.if_rw)  modelWrite(v.if_addr, v.if_wd, v.if_be);
            if (gm && !v.mem_rw) modelWrite(v.mem_addr, v.mem_wd, v.mem_be);
            if (conflict) m_prio = gm;
            m_if_stall  = v.if_req && !gi;
            m_mem_stall = v.mem_req && !gm;
        end
        @(posedge clk);
        #1;
    endtask

    vec_t tbl[$];
    vec_t v, prev;

    initial begin
        for (int i = 0; i < 4096; i++) m_known[i] = 1'b0;
        m_prio = 1'b0; m_if_rd = '0; m_mem_rd = '0; m_if_ok = 1'b0; m_mem_ok = 1'b0;
        m_if_stall = 1'b0; m_mem_stall = 1'b0;
        b1_reset = 1'b1; b1_if_as_ = 1'b1; b1_mem_as_ = 1'b1; b1_if_rw = 1'b1; b1_mem_rw = 1'b1;
        b1_if_addr = '0; b1_mem_addr = '0; b1_if_wd = '0; b1_mem_wd = '0; b1_if_be = '0; b1_mem_be = '0;

        // Reset and preload.
        tbl.push_back(rdy(mk(1, OI, 0, 0, 0, OI, 0, 0, 0), 1, 1));
        tbl.push_back(rdy(mk(0, OWR, 12'h004, 32'hA0040004, 4'hF, OI, 0, 0, 0), 0, 1));
        tbl.push_back(mk(0, OWR, 12'h010, 32'h10101010, 4'hF, OI, 0, 0, 0));
        tbl.push_back(mk(0, OWR, 12'h020, 32'h20202020, 4'hF, OI, 0, 0, 0));
        tbl.push_back(mk(0, OWR, 12'h200, 32'hCAFEF00D, 4'hF, OI, 0, 0, 0));
        tbl.push_back(mk(0, OWR, 12'h300, 32'h33333333, 4'hF, OI, 0, 0, 0));
        // Different banks served together.
        tbl.push_back(eif(rdy(mk(0, ORD, 12'h004, 0, 0, OWR, 12'h005, 32'hDEADBEEF, 4'hF), 0, 0), 32'h0));
        tbl.push_back(eif(rdy(mk(0, ORD, 12'h005, 0, 0, OI, 0, 0, 0), 0, 1), 32'hA0040004));
        tbl.push_back(eif(mk(0, OI, 0, 0, 0, OI, 0, 0, 0), 32'hDEADBEEF));
        // Same-bank conflict alternation: MEM, IF, MEM, IF.
        tbl.push_back(emem(eif(rdy(mk(0, ORD, 12'h010, 0, 0, ORD, 12'h020, 0, 0), 1, 0), 32'hDEADBEEF), 32'h0));
        tbl.push_back(emem(eif(rdy(mk(0, ORD, 12'h010, 0, 0, ORD, 12'h020, 0, 0), 0, 1), 32'hDEADBEEF), 32'h20202020));
        tbl.push_back(emem(eif(rdy(mk(0, ORD, 12'h010, 0, 0, ORD, 12'h020, 0, 0), 1, 0), 32'h10101010), 32'h20202020));
        tbl.push_back(rdy(mk(0, ORD, 12'h010, 0, 0, ORD, 12'h020, 0, 0), 0, 1));
        tbl.push_back(emem(eif(mk(0, OI, 0, 0, 0, OI, 0, 0, 0), 32'h10101010), 32'h20202020));
        // Byte enables, including an all-zero enable.
        tbl.push_back(mk(0, OI, 0, 0, 0, OWR, 12'h100, 32'h11223344, 4'hF));
        tbl.push_back(mk(0, OI, 0, 0, 0, OWR, 12'h100, 32'hAABBCCDD, 4'b0101));
        tbl.push_back(rdy(mk(0, OI, 0, 0, 0, OWR, 12'h100, 32'hFFFFFFFF, 4'h0), 1, 0));
        tbl.push_back(mk(0, OI, 0, 0, 0, ORD, 12'h100, 0, 0));
        tbl.push_back(emem(mk(0, OI, 0, 0, 0, OI, 0, 0, 0), 32'h11BB33DD));
        // Read data holds across a write, idle cycles and the other port using the same bank.
        tbl.push_back(mk(0, ORD, 12'h200, 0, 0, OI, 0, 0, 0));
        tbl.push_back(eif(mk(0, OWR, 12'h202, 32'h55555555, 4'hF, OI, 0, 0, 0), 32'hCAFEF00D));
        tbl.push_back(eif(mk(0, OI, 0, 0, 0, ORD, 12'h010, 0, 0), 32'hCAFEF00D));
        tbl.push_back(emem(eif(mk(0, OI, 0, 0, 0, OI, 0, 0, 0), 32'hCAFEF00D), 32'h10101010));
        // Reset after MEM wins a conflict, with a write that must be dropped.
        tbl.push_back(rdy(mk(0, ORD, 12'h010, 0, 0, ORD, 12'h020, 0, 0), 1, 0));
        tbl.push_back(rdy(mk(1, OI, 0, 0, 0, OWR, 12'h300, 32'h12345678, 4'hF), 1, 0));
        tbl.push_back(emem(eif(mk(0, OI, 0, 0, 0, OI, 0, 0, 0), 32'h0), 32'h0));
        tbl.push_back(rdy(mk(0, ORD, 12'h300, 0, 0, ORD, 12'h010, 0, 0), 1, 0));
        tbl.push_back(emem(rdy(mk(0, ORD, 12'h300, 0, 0, OI, 0, 0, 0), 0, 1), 32'h10101010));
        tbl.push_back(emem(eif(mk(0, OI, 0, 0, 0, OI, 0, 0, 0), 32'h33333333), 32'h10101010));
        // Same port write then read; read granted just before reset.
        tbl.push_back(mk(0, OWR, 12'h301, 32'h77777777, 4'hF, OI, 0, 0, 0));
        tbl.push_back(mk(0, ORD, 12'h301, 0, 0, OI, 0, 0, 0));
        tbl.push_back(eif(mk(0, OI, 0, 0, 0, OI, 0, 0, 0), 32'h77777777));
        tbl.push_back(mk(0, ORD, 12'h004, 0, 0, OI, 0, 0, 0));
        tbl.push_back(mk(1, OI, 0, 0, 0, OI, 0, 0, 0));
        tbl.push_back(eif(mk(0, OI, 0, 0, 0, OI, 0, 0, 0), 32'h0));

        for (int i = 0; i < tbl.size(); i++) applyStimulus(tbl[i]);

        // Fill the random working set so every read has a known answer.
        for (int a = 0; a < 64; a++) applyStimulus(mk(0, OWR, 12'(a), $urandom, 4'hF, OI, 0, 0, 0));

        // Random traffic; a stalled port keeps its request until granted.
        prev = mk(0, OI, 0, 0, 0, OI, 0, 0, 0);
        for (int n = 0; n < 400; n++) begin
            v = prev;
            if (!m_if_stall) begin
                v.if_req = ($urandom_range(0, 3) != 0); v.if_rw = 1'($urandom_range(0, 1));
                v.if_addr = 12'($urandom_range(0, 63)); v.if_wd = $urandom; v.if_be = 4'($urandom_range(0, 15));
            end
            if (!m_mem_stall) begin
                v.mem_req = ($urandom_range(0, 3) != 0); v.mem_rw = 1'($urandom_range(0, 1));
                v.mem_addr = 12'($urandom_range(0, 63)); v.mem_wd = $urandom; v.mem_be = 4'($urandom_range(0, 15));
            end
            applyStimulus(v);
            prev = v;
        end
        applyStimulus(mk(0, OI, 0, 0, 0, OI, 0, 0, 0));

        // Single-bank build: every dual request conflicts; full address range round trip.
        @(posedge clk); #1;
        b1_reset = 1'b0;
        for (int a = 0; a < 256; a++) begin
            b1_ref[a] = $urandom;
            b1_if_as_ = 1'b1; b1_mem_as_ = 1'b1;
            if (a % 2 == 0) begin
                b1_if_as_ = 1'b0; b1_if_rw = 1'b0; b1_if_addr = 8'(a); b1_if_wd = b1_ref[a]; b1_if_be = 4'hF;
            end else begin
                b1_mem_as_ = 1'b0; b1_mem_rw = 1'b0; b1_mem_addr = 8'(a); b1_mem_wd = b1_ref[a]; b1_mem_be = 4'hF;
            end
            @(negedge clk);
            if (a % 2 == 0) checkOutput("b1_if_wr_rdy", 32'(b1_if_rdy_), 32'(0));
            else            checkOutput("b1_mem_wr_rdy", 32'(b1_mem_rdy_), 32'(0));
            @(posedge clk); #1;
        end
        b1_if_as_ = 1'b0; b1_if_rw = 1'b1; b1_if_addr = 8'h01;
        b1_mem_as_ = 1'b0; b1_mem_rw = 1'b1; b1_mem_addr = 8'h80;
        @(negedge clk);
        checkOutput("b1_conf1_if_rdy", 32'(b1_if_rdy_), 32'(1));
        checkOutput("b1_conf1_mem_rdy", 32'(b1_mem_rdy_), 32'(0));
        @(posedge clk); #1;
        @(negedge clk);
        checkOutput("b1_conf2_if_rdy", 32'(b1_if_rdy_), 32'(0));
        checkOutput("b1_conf2_mem_rdy", 32'(b1_mem_rdy_), 32'(1));
        checkOutput("b1_conf2_mem_rd", b1_mem_rd, b1_ref[8'h80]);
        @(posedge clk); #1;
        b1_if_as_ = 1'b1; b1_mem_as_ = 1'b1;
        @(negedge clk);
        checkOutput("b1_conf3_if_rd", b1_if_rd, b1_ref[8'h01]);
        @(posedge clk); #1;
        for (int a = 0; a <= 256; a++) begin
            b1_mem_as_ = (a < 256) ? 1'b0 : 1'b1; b1_mem_rw = 1'b1; b1_mem_addr = 8'(a);
            @(negedge clk);
            if (a > 0) checkOutput("b1_readback", b1_mem_rd, b1_ref[a-1]);
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/spm_banked.md
Name: spm_banked

Overview:
- Parametrised next-generation scratchpad memory (SPM) shared by the IF stage and the MEM stage.
- Storage is split into BANKS word-interleaved single-port banks.
  - Both ports are served in the same cycle when they address different banks.
  - A same-bank collision is arbitrated with alternating priority, and the losing port is stalled through an active-low ready.
- Adds per-byte write enables and a registered read path with a fixed 1-cycle latency.
- Sits between the IF/MEM pipeline stages and on-chip RAM, replacing the fixed 4K-word dual-port SPM.

Parameters:
- ADDR_W, 12, word address width; total depth = 2**ADDR_W words.
- DATA_W, 32, data width in bits; must be a multiple of 8.
- BANKS, 2, number of banks; power of two, 1..2**ADDR_W.

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- if_spm_addr  in  ADDR_W  IF port word address.
- if_spm_as_  in  1  IF address strobe, active low (0 = request).
- if_spm_rw  in  1  IF direction: 1 = READ, 0 = WRITE.
- if_spm_wr_data  in  DATA_W  IF write data.
- if_spm_be  in  DATA_W/8  IF byte write enables, active high.
- if_spm_rdy_  out  1  IF ready, active low; combinational; 0 = request granted this cycle.
- if_spm_rd_data  out  DATA_W  IF read data, registered.
- mem_spm_addr, mem_spm_as_, mem_spm_rw, mem_spm_wr_data, mem_spm_be, mem_spm_rdy_, mem_spm_rd_data: identical set for the MEM port.

Behaviour:
- Address split:
  - bank = addr[log2(BANKS)-1:0]
  - row = addr[ADDR_W-1:log2(BANKS)]
  - BANKS=1: no bank bits; every dual request is a conflict.
- Request rules:
  - A port requests when as_=0.
  - rdy_ is combinational from the current request, the other port's request and the if_prio register.
  - rdy_=1 whenever as_=1.
- Conflict:
  - Defined as both as_=0 with equal bank fields.
  - Winner = IF if if_prio=1, else MEM; the loser sees rdy_=1.
  - The loser must hold addr, rw, data and be unchanged until it sees rdy_=0; the block keeps no loser state.
- Priority register if_prio:
  - Reset value 0 (MEM first).
  - On a conflict cycle: if_prio <= 1 if MEM won, 0 if IF won.
  - Otherwise unchanged.
  - Guarantees that neither port waits more than 1 cycle per conflict.
- Granted write:
  - Bytes with be[i]=1 are written at the end of the grant cycle; other bytes are untouched.
  - be=0 is a granted no-op.
  - rd_data is not changed.
- Granted read:
  - rd_data presents the word on the cycle after the grant (latency 1).
  - rd_data holds that value until the port's next granted read.
  - Stalled cycles and writes do not disturb it.
- Read-after-write through the other port: allowed only in a later cycle and returns the new data. Same-cycle access to the same address is impossible because it is always a bank conflict.
- Same port, back-to-back write then read of the same address: the read returns the written data.
- Reset:
  - if_prio=0, both rd_data registers=0.
  - rdy_ outputs follow the request inputs, since they are combinational.
  - RAM contents are not cleared.
  - A write granted in the same cycle that reset is high is suppressed.
  - A read granted in the cycle before reset asserts yields rd_data=0 instead of the word.
- Out-of-range: none; every ADDR_W value maps to a valid word.

Decomposition:
- Package spm_pkg:
  - READ=1'b1, WRITE=1'b0, ENABLE_=1'b0, DISABLE_=1'b1.
  - A function clog2 for bank-bit width.
- Sub-module spm_bank, instantiated BANKS times:
  - Single-port RAM, depth 2**ADDR_W/BANKS, DATA_W wide.
  - Byte-enable write, synchronous read (registered output), no reset on the array.
- Top level contains the arbiter, per-bank port mux and read-return steering.
- Read-return steering uses one registered {valid, bank} per port, because the bank output is already registered.

Test Plan:
- No conflict, defaults:
  - Stimulus: IF reads 0x004 (bank 0) while MEM writes 0xDEADBEEF, be=4'hF, to 0x005 (bank 1).
  - Required: both rdy_=0 in the same cycle; IF rd_data valid next cycle.
  - Follow-up: IF reading 0x005 afterwards returns 0xDEADBEEF.
- Conflict alternation:
  - Stimulus: both ports continuously read bank 0 (IF 0x010, MEM 0x020) for 4 cycles.
  - Required grants: MEM, IF, MEM, IF; each port's rd_data updates only on the cycle after its own grant.
- Byte enables:
  - Stimulus: write 0x11223344 to 0x100, then write 0xAABBCCDD with be=4'b0101.
  - Required: a read returns 0x11BB33DD.
  - Follow-up: a write with be=0 leaves the word unchanged.
- Read hold:
  - Stimulus: IF reads 0x200 (=0xCAFEF00D), then issues a write and 2 idle cycles.
  - Required: if_spm_rd_data stays 0xCAFEF00D.
- Reset mid-operation:
  - Stimulus: after MEM wins a conflict (if_prio=1), assert reset together with an MEM write to 0x300 (0x12345678).
  - Required after reset: rd_data=0 on both ports; if_prio=0 (the next conflict goes to MEM); 0x300 still holds its pre-reset value.
- BANKS=1, ADDR_W=8:
  - Stimulus: simultaneous requests to 0x01 and 0x80.
  - Required: serialised MEM then IF; every address 0x00..0xFF is writable and readable back.
